// File: rtl/led_matrix_scanner.sv
// Frame-buffered scanner for a 16x8 red/green LED matrix fed by a pixel word stream.
// Optional SCAN_GHOST_BLANK_EN enables a BLANK_CYC all-off window at the start of each row.
module led_matrix_scanner #(
    parameter int ROWS      = 16,
    parameter int COLS      = 8,
    parameter int SCAN_DIV  = 2000,
    parameter int BLANK_CYC = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [9:0]      PIX_IN,
    input  logic            PIX_VALID,
    input  logic            FRAME_END,
    output logic [ROWS-1:0] ROW_SEL,
    output logic [COLS-1:0] COL_RED,
    output logic [COLS-1:0] COL_GRN,
    output logic [3:0]      ROW_IDX,
    output logic [7:0]      FRAME_CNT
);

    localparam logic [15:0] LAST_CNT = 16'(SCAN_DIV - 1);
    localparam logic [ROWS-1:0] ROW_ONE = {{(ROWS-1){1'b0}}, 1'b1};

    logic [ROWS-1:0][COLS-1:0] back_red_q, back_grn_q;
    logic [ROWS-1:0][COLS-1:0] front_red_q, front_grn_q;
    logic [ROWS-1:0][COLS-1:0] wr_red_d, wr_grn_d;

    logic [15:0]     row_cnt_q, row_cnt_d;
    logic [3:0]      row_idx_q, row_idx_d;
    logic [7:0]      frame_cnt_q;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic [COLS-1:0] col_red_q, col_red_d;
    logic [COLS-1:0] col_grn_q, col_grn_d;

    logic [3:0] pix_row;
    logic [2:0] pix_col;
    logic       row_wrap;
    logic       blank;
    logic       unused_rsvd;

    assign pix_row     = PIX_IN[6:3];
    assign pix_col     = PIX_IN[2:0];
    assign unused_rsvd = PIX_IN[7];

    // The swap takes wr_*_d, so a pixel arriving with FRAME_END lands in the new front.
    always_comb begin
        wr_red_d = back_red_q;
        wr_grn_d = back_grn_q;
        if (PIX_VALID) begin
            wr_red_d[pix_row][pix_col] = back_red_q[pix_row][pix_col] | PIX_IN[9];
            wr_grn_d[pix_row][pix_col] = back_grn_q[pix_row][pix_col] | PIX_IN[8];
        end
    end

    assign row_wrap  = (row_cnt_q == LAST_CNT);
    assign row_cnt_d = row_wrap ? 16'd0 : row_cnt_q + 16'd1;
    assign row_idx_d = row_wrap ? row_idx_q + 4'd1 : row_idx_q;

`ifdef SCAN_GHOST_BLANK_EN
    assign blank = (row_cnt_q < 16'(BLANK_CYC));
`else
    logic unused_blank;
    assign blank        = 1'b0;
    assign unused_blank = (BLANK_CYC != 0);
`endif

    always_comb begin
        row_sel_d = '0;
        col_red_d = '0;
        col_grn_d = '0;
        if (!blank) begin
            row_sel_d = ROW_ONE << row_idx_q;
            col_red_d = front_red_q[row_idx_q];
            col_grn_d = front_grn_q[row_idx_q];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            back_red_q  <= '0;
            back_grn_q  <= '0;
            front_red_q <= '0;
            front_grn_q <= '0;
            row_cnt_q   <= '0;
            row_idx_q   <= '0;
            frame_cnt_q <= '0;
            row_sel_q   <= '0;
            col_red_q   <= '0;
            col_grn_q   <= '0;
        end else begin
            if (FRAME_END) begin
                front_red_q <= wr_red_d;
                front_grn_q <= wr_grn_d;
                back_red_q  <= '0;
                back_grn_q  <= '0;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end else begin
                back_red_q  <= wr_red_d;
                back_grn_q  <= wr_grn_d;
            end
            row_cnt_q <= row_cnt_d;
            row_idx_q <= row_idx_d;
            row_sel_q <= row_sel_d;
            col_red_q <= col_red_d;
            col_grn_q <= col_grn_d;
        end
    end

    assign ROW_SEL   = row_sel_q;
    assign COL_RED   = col_red_q;
    assign COL_GRN   = col_grn_q;
    assign ROW_IDX   = row_idx_q;
    assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner (SCAN_DIV=16, BLANK_CYC=4).
// Blank-window expectations follow whether SCAN_GHOST_BLANK_EN is defined.
module tb_led_matrix_scanner;

    localparam int SD = 16;
`ifdef SCAN_GHOST_BLANK_EN
    localparam int BLANK_EXP = 4;
`else
    localparam int BLANK_EXP = 0;
`endif

    logic        CLK;
    logic        RST;
    logic [9:0]  PIX_IN;
    logic        PIX_VALID;
    logic        FRAME_END;
    logic [15:0] ROW_SEL;
    logic [7:0]  COL_RED;
    logic [7:0]  COL_GRN;
    logic [3:0]  ROW_IDX;
    logic [7:0]  FRAME_CNT;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_fc = 8'd0;

    led_matrix_scanner #(
        .ROWS(16), .COLS(8), .SCAN_DIV(SD), .BLANK_CYC(4)
    ) dut (
        .CLK(CLK), .RST(RST), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID),
        .FRAME_END(FRAME_END), .ROW_SEL(ROW_SEL), .COL_RED(COL_RED),
        .COL_GRN(COL_GRN), .ROW_IDX(ROW_IDX), .FRAME_CNT(FRAME_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic pix(input logic [9:0] w, input logic fe);
        @(negedge CLK);
        PIX_IN    = w;
        PIX_VALID = 1'b1;
        FRAME_END = fe;
        @(negedge CLK);
        PIX_VALID = 1'b0;
        FRAME_END = 1'b0;
        PIX_IN    = 10'd0;
        if (fe) exp_fc = exp_fc + 8'd1;
    endtask

    task automatic swap();
        @(negedge CLK);
        FRAME_END = 1'b1;
        @(negedge CLK);
        FRAME_END = 1'b0;
        exp_fc = exp_fc + 8'd1;
    endtask

    // Waits for a fresh entry into row r, then past the blank window.
    task automatic wait_show(input logic [3:0] r, output logic ok);
        int n = 0;
        ok = 1'b0;
        while (ROW_IDX == r && n < 400) begin @(negedge CLK); n++; end
        while (ROW_IDX != r && n < 400) begin @(negedge CLK); n++; end
        if (n < 400) begin
            ok = 1'b1;
            repeat (5) @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; PIX_IN = '0; PIX_VALID = 1'b0; FRAME_END = 1'b0;
        repeat (2) @(negedge CLK);
        n_total++;
        if (ROW_SEL !== 16'h0) $display("FAIL reset_rowsel got %h want 0", ROW_SEL);
        else n_pass++;
        n_total++;
        if (COL_RED !== 8'h0 || COL_GRN !== 8'h0)
            $display("FAIL reset_cols got %h/%h want 0/0", COL_RED, COL_GRN);
        else n_pass++;
        n_total++;
        if (ROW_IDX !== 4'd0 || FRAME_CNT !== 8'd0)
            $display("FAIL reset_idx_cnt got %0d/%0d want 0/0", ROW_IDX, FRAME_CNT);
        else n_pass++;
        RST = 1'b0;
    endtask

    task automatic test_write_swap();
        logic ok;
        pix(10'b10_0_1101_000, 1'b0);
        swap();
        n_total++;
        if (FRAME_CNT !== exp_fc) $display("FAIL ws_fcnt got %0d want %0d", FRAME_CNT, exp_fc);
        else n_pass++;
        wait_show(4'd13, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL ws_wait13 got timeout want row 13");
        else n_pass++;
        n_total++;
        if (ROW_SEL !== 16'h2000) $display("FAIL ws_rowsel got %h want 2000", ROW_SEL);
        else n_pass++;
        n_total++;
        if (COL_RED !== 8'h01 || COL_GRN !== 8'h00)
            $display("FAIL ws_cols got %h/%h want 01/00", COL_RED, COL_GRN);
        else n_pass++;
        wait_show(4'd14, ok);
        n_total++;
        if (ok !== 1'b1 || COL_RED !== 8'h00 || ROW_SEL !== 16'h4000)
            $display("FAIL ws_row14 got %b %h %h want 1 00 4000", ok, COL_RED, ROW_SEL);
        else n_pass++;
    endtask

    task automatic test_swap_same_cycle();
        logic ok;
        pix(10'b01_0_0011_011, 1'b1);
        n_total++;
        if (FRAME_CNT !== exp_fc) $display("FAIL sc_fcnt got %0d want %0d", FRAME_CNT, exp_fc);
        else n_pass++;
        wait_show(4'd3, ok);
        n_total++;
        if (ok !== 1'b1 || COL_GRN !== 8'h08 || COL_RED !== 8'h00)
            $display("FAIL sc_row3 got %b %h/%h want 1 00/08", ok, COL_RED, COL_GRN);
        else n_pass++;
        wait_show(4'd13, ok);
        n_total++;
        if (ok !== 1'b1 || COL_RED !== 8'h00)
            $display("FAIL sc_row13_cleared got %b %h want 1 00", ok, COL_RED);
        else n_pass++;
        swap();
        wait_show(4'd3, ok);
        n_total++;
        if (ok !== 1'b1 || COL_GRN !== 8'h00)
            $display("FAIL sc_back_empty got %b %h want 1 00", ok, COL_GRN);
        else n_pass++;
    endtask

    task automatic test_or_merge();
        logic ok;
        pix(10'b10_0_0101_010, 1'b0);
        pix(10'b10_0_0101_010, 1'b0);
        pix(10'b01_0_0101_010, 1'b0);
        pix(10'b10_0_0101_111, 1'b0);
        pix(10'b10_1_0101_001, 1'b0);
        pix(10'b00_0_0101_100, 1'b0);
        pix(10'b00_1_0110_000, 1'b0);
        swap();
        wait_show(4'd5, ok);
        n_total++;
        if (ok !== 1'b1 || COL_RED !== 8'h86 || COL_GRN !== 8'h04)
            $display("FAIL or_row5 got %b %h/%h want 1 86/04", ok, COL_RED, COL_GRN);
        else n_pass++;
        wait_show(4'd6, ok);
        n_total++;
        if (ok !== 1'b1 || COL_RED !== 8'h00 || COL_GRN !== 8'h00)
            $display("FAIL or_row6_blankword got %b %h/%h want 1 00/00", ok, COL_RED, COL_GRN);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        PIX_IN = 10'b10_0_1001_001;
        PIX_VALID = 1'b1;
        @(negedge CLK);
        PIX_VALID = 1'b0;
        FRAME_END = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        FRAME_END = 1'b0;
        exp_fc = exp_fc + 8'd2;
        n_total++;
        if (FRAME_CNT !== exp_fc) $display("FAIL b2b_fcnt got %0d want %0d", FRAME_CNT, exp_fc);
        else n_pass++;
    endtask

    task automatic test_scan();
        logic [3:0] r0, start, exp_row;
        logic [7:0] col_or = 8'h00;
        logic onehot_ok = 1'b1;
        logic idx_ok;
        int zeros;
        int n = 0;
        r0 = ROW_IDX;
        while (ROW_IDX == r0 && n < 40) begin @(negedge CLK); n++; end
        n_total++;
        if (n >= 40) $display("FAIL scan_sync got timeout want row change");
        else n_pass++;
        start = ROW_IDX;
        for (int i = 0; i < 16; i++) begin
            exp_row = start + 4'(i);
            zeros = 0;
            idx_ok = 1'b1;
            for (int c = 0; c < SD; c++) begin
                if (ROW_IDX !== exp_row) idx_ok = 1'b0;
                if (ROW_SEL == 16'h0) zeros++;
                else if ((ROW_SEL & (ROW_SEL - 16'd1)) != 16'h0) onehot_ok = 1'b0;
                col_or = col_or | COL_RED | COL_GRN;
                @(negedge CLK);
            end
            n_total++;
            if (idx_ok !== 1'b1) $display("FAIL scan_rowlen row %0d got wrong ROW_IDX want %0d", i, exp_row);
            else n_pass++;
            n_total++;
            if (zeros != BLANK_EXP) $display("FAIL scan_blank row %0d got %0d want %0d", i, zeros, BLANK_EXP);
            else n_pass++;
        end
        n_total++;
        if (ROW_IDX !== start) $display("FAIL scan_wrap got %0d want %0d", ROW_IDX, start);
        else n_pass++;
        n_total++;
        if (onehot_ok !== 1'b1) $display("FAIL scan_onehot got multi-hot want one-hot");
        else n_pass++;
        n_total++;
        if (col_or !== 8'h00) $display("FAIL scan_empty_frame got %h want 00", col_or);
        else n_pass++;
    endtask

    task automatic test_frame_wrap();
        logic [7:0] base;
        base = exp_fc;
        @(negedge CLK);
        FRAME_END = 1'b1;
        repeat (255) @(negedge CLK);
        n_total++;
        if (FRAME_CNT !== base + 8'd255)
            $display("FAIL fw_255 got %0d want %0d", FRAME_CNT, base + 8'd255);
        else n_pass++;
        @(negedge CLK);
        FRAME_END = 1'b0;
        n_total++;
        if (FRAME_CNT !== base) $display("FAIL fw_wrap got %0d want %0d", FRAME_CNT, base);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic ok;
        pix(10'b10_0_0111_101, 1'b0);
        swap();
        wait_show(4'd7, ok);
        n_total++;
        if (ok !== 1'b1 || COL_RED !== 8'h20 || ROW_SEL !== 16'h0080)
            $display("FAIL rm_pre got %b %h %h want 1 20 0080", ok, COL_RED, ROW_SEL);
        else n_pass++;
        #2;
        RST = 1'b1;
        #1;
        n_total++;
        if (ROW_SEL !== 16'h0 || COL_RED !== 8'h0 || COL_GRN !== 8'h0 ||
            ROW_IDX !== 4'd0 || FRAME_CNT !== 8'd0)
            $display("FAIL rm_async got %h %h %h %0d %0d want all 0",
                     ROW_SEL, COL_RED, COL_GRN, ROW_IDX, FRAME_CNT);
        else n_pass++;
        exp_fc = 8'd0;
        @(negedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        n_total++;
        if (ROW_IDX !== 4'd0 || ROW_SEL !== (BLANK_EXP == 0 ? 16'h0001 : 16'h0000))
            $display("FAIL rm_restart got %0d %h want 0 %h", ROW_IDX, ROW_SEL,
                     (BLANK_EXP == 0 ? 16'h0001 : 16'h0000));
        else n_pass++;
        wait_show(4'd7, ok);
        n_total++;
        if (ok !== 1'b1 || COL_RED !== 8'h00 || FRAME_CNT !== exp_fc)
            $display("FAIL rm_blank_front got %b %h %0d want 1 00 %0d", ok, COL_RED, FRAME_CNT, exp_fc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_swap();
        test_swap_same_cycle();
        test_or_merge();
        test_back_to_back();
        test_scan();
        test_frame_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Receiving end of the game logic's 10-bit time-multiplexed pixel word stream (LEDout).
- Collects the pixel words of one frame into a back buffer and presents the finished frame from a front buffer at frame boundaries.
- Scans the front buffer row by row onto a 16x8 two-colour LED matrix: one-hot row select plus red/green column drives.
- Sits between the game core and the board's matrix pins.

Parameters:
- ROWS, 16, matrix rows; fixed at 16 in this revision because the row address is 4 bits.
- COLS, 8, matrix columns; fixed at 8 in this revision because the column address is 3 bits.
- SCAN_DIV, 2000, clocks per displayed row; legal range is 2..65535.
- BLANK_CYC, 64, clocks at the start of each row during which all drives are off; must be less than SCAN_DIV.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- PIX_IN  in  10  pixel word: [9]=red, [8]=green, [7]=reserved (ignored), [6:3]=row, [2:0]=column.
- PIX_VALID  in  1  PIX_IN is sampled on every cycle this is high.
- FRAME_END  in  1  single-cycle pulse marking the end of the producer's frame.
- ROW_SEL  out  16  one-hot row drive, active high.
- COL_RED  out  8  red column drives for the selected row; bit n = column n.
- COL_GRN  out  8  green column drives for the selected row.
- ROW_IDX  out  4  row currently being scanned.
- FRAME_CNT  out  8  number of completed frame swaps, mod 256.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is CLK, reset port is RST.
- Reset values: ROW_SEL=0, COL_RED=0, COL_GRN=0, ROW_IDX=0, FRAME_CNT=0. Internally, both buffers are all 0 and the row timer is 0.
- Write path: a word with PIX_VALID=1 ORs its [9] into back_red[row][col] and its [8] into back_grn[row][col].
  - A word with [9:8]=00 changes nothing.
  - Writes set bits only. Repeated writes to the same pixel are idempotent.
- Swap: on a cycle with FRAME_END=1:
  - front <= back, including any pixel written on that same cycle.
  - back <= all 0.
  - FRAME_CNT increments; 255 wraps to 0.
  - Frames are never merged. Two consecutive FRAME_END cycles leave the front buffer all 0.
- Row timer:
  - row_cnt counts 0..SCAN_DIV-1.
  - When row_cnt=SCAN_DIV-1: row_cnt goes to 0 and ROW_IDX increments, with 15 wrapping to 0.
- Drive outputs: registered, one clock of latency from the row timer and the front buffer.
  - If row_cnt < BLANK_CYC, the next cycle shows ROW_SEL=0, COL_RED=0, COL_GRN=0.
  - Otherwise the next cycle shows ROW_SEL=1<<ROW_IDX, COL_RED=front_red[ROW_IDX], COL_GRN=front_grn[ROW_IDX].
- A front-buffer update in the middle of a row is visible on the next cycle; there is no row-boundary synchronisation.
- ROW_SEL is always either 0 or exactly one-hot.
- The reserved bit [7] has no effect. No address is out of range: 4-bit row × 3-bit column = 128 pixels.
- RST asserted mid-row or mid-frame: all state clears immediately. The first row after release is row 0 with row_cnt=0.

Optional Feature:
- Macro: SCAN_GHOST_BLANK_EN.
- Defined: the BLANK_CYC blanking window at the start of each row is implemented as described above.
- Not defined: BLANK_CYC is ignored, there is no blanking, and drives switch directly from one row to the next.
  - ROW_SEL is then one-hot from the second cycle after reset onward.

Test Plan:
- Write and swap, then check the row display (SCAN_DIV=16, BLANK_CYC=4, macro defined):
  - Stimulus: PIX_VALID with PIX_IN=10'b1001101000 (red, row 13, col 0), then a FRAME_END pulse.
  - Required response: while ROW_IDX=13, after the 4 blank cycles, ROW_SEL=16'h2000, COL_RED=8'h01, COL_GRN=0.
- Pixel write on the swap cycle:
  - Stimulus: PIX_IN=10'b0100011011 (green, row 3, col 3) with PIX_VALID=1 on the same cycle as FRAME_END.
  - Required response: front_grn row 3 = 8'h08; the back buffer is all 0; FRAME_CNT increases by 1.
- Empty frame and frame counter wrap:
  - Stimulus: two consecutive FRAME_END pulses, then 256 FRAME_END pulses in total.
  - Required response: every row shows COL_RED=COL_GRN=0; FRAME_CNT returns to its starting value.
- Blank words and ghost blanking:
  - Stimulus: PIX_IN with [9:8]=00 and PIX_VALID=1, then FRAME_END.
  - Required response: no column drive is ever set.
  - Required response: ROW_SEL=0 for exactly BLANK_CYC cycles after each row change; without the macro, it is never 0 after the first cycle.
- Row scan wrap:
  - Stimulus: run free for 16×SCAN_DIV clocks.
  - Required response: ROW_IDX steps 0..15, then back to 0; each row lasts exactly SCAN_DIV clocks.
- Reset mid-operation:
  - Stimulus: assert RST while ROW_IDX=7 and the front buffer is non-zero.
  - Required response: all outputs go to 0 without a clock edge; after release, scanning restarts at row 0 with a blank front buffer.
